// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer and the instruction decoder:
// instruction field widths, opcode constants, the sequencer state type and
// an opcode extraction helper.
package layer_sequencer_pkg;

    localparam int INSTRUCTION_LENGTH = 10;
    localparam int OPCODE_LENGTH      = 3;
    localparam int ADDR_LENGTH        = 7;

    localparam int DEFAULT_PC_W  = 8;
    localparam int DEFAULT_CNT_W = 16;

    localparam logic [OPCODE_LENGTH-1:0] OP_NOP   = 3'b000;
    localparam logic [OPCODE_LENGTH-1:0] OP_STORE = 3'b001;
    localparam logic [OPCODE_LENGTH-1:0] OP_LOAD  = 3'b010;
    localparam logic [OPCODE_LENGTH-1:0] OP_ACC0  = 3'b100;
    localparam logic [OPCODE_LENGTH-1:0] OP_ACCI  = 3'b110;
    localparam logic [OPCODE_LENGTH-1:0] OP_STOP  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_LOAD = 2'd2,
        ST_DONE      = 2'd3
    } seq_state_t;

    function automatic logic [OPCODE_LENGTH-1:0] opcode_of(
        input logic [INSTRUCTION_LENGTH-1:0] instr
    );
        return instr[OPCODE_LENGTH+ADDR_LENGTH-1:ADDR_LENGTH];
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Instruction-path bundle between the layer sequencer (master) and the
// instruction memory / decoder / load unit side (slave).
//   imem_en, imem_addr : memory read request (master -> slave)
//   imem_rdata         : memory read data, one cycle after imem_en
//   instr_out          : instruction handed to the decoder, zero when idle
//   load_rsp_vld       : load-unit completion pulse for the outstanding LOAD
interface layer_sequencer_if #(
    parameter int PC_W = layer_sequencer_pkg::DEFAULT_PC_W
) ();
    logic                                              imem_en;
    logic [PC_W-1:0]                                   imem_addr;
    logic [layer_sequencer_pkg::INSTRUCTION_LENGTH-1:0] imem_rdata;
    logic [layer_sequencer_pkg::INSTRUCTION_LENGTH-1:0] instr_out;
    logic                                              load_rsp_vld;

    modport master (
        output imem_en,
        output imem_addr,
        output instr_out,
        input  imem_rdata,
        input  load_rsp_vld
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        input  instr_out,
        output imem_rdata,
        output load_rsp_vld
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer sequencer: streams one aggregation layer's instructions from the
// synchronous instruction memory to the decoder, one per cycle, stalling on
// LOAD until the load unit responds and ending the layer on STOP.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, accepted only in IDLE
//   base_pc     : first instruction address, sampled with start
//   busy        : high in every state except IDLE
//   layer_done  : registered one-cycle pulse after STOP is presented
//   instr_cnt   : instructions presented since the last accepted start (saturating)
//   bus         : instruction memory / decoder / load-unit interface (master)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; no fetch
// RUN       | fetching and presenting one instruction per cycle
// WAIT_LOAD | LOAD presented; fetch halted until load_rsp_vld
// DONE      | STOP presented; layer_done pulses, back to IDLE next cycle
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int PC_W  = DEFAULT_PC_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PC_W-1:0]  base_pc,
    output logic             busy,
    output logic             layer_done,
    output logic [CNT_W-1:0] instr_cnt,
    layer_sequencer_if.master bus
);

    seq_state_t state, state_nxt;

    logic [PC_W-1:0]          pc;
    logic                     rd_vld;
    logic                     present;
    logic [OPCODE_LENGTH-1:0] rd_op;
    logic                     is_load;
    logic                     is_stop;

    assign rd_op   = opcode_of(bus.imem_rdata);
    assign is_load = rd_vld && (rd_op == OP_LOAD);
    assign is_stop = rd_vld && (rd_op == OP_STOP);

    always_comb begin
        state_nxt     = state;
        bus.imem_en   = 1'b0;
        bus.instr_out = '0;
        present       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                present       = rd_vld;
                bus.instr_out = rd_vld ? bus.imem_rdata : '0;
                // Squash the fetch when LOAD/STOP is on the read port so that
                // nothing is in flight once the stream stalls or ends.
                bus.imem_en   = !(is_load || is_stop);
                if (is_load)      state_nxt = ST_WAIT_LOAD;
                else if (is_stop) state_nxt = ST_DONE;
            end
            ST_WAIT_LOAD: begin
                if (bus.load_rsp_vld) state_nxt = ST_RUN;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            rd_vld     <= 1'b0;
            layer_done <= 1'b0;
            instr_cnt  <= '0;
        end else begin
            // imem_en is only ever high in RUN, so this also clears rd_vld
            // in every other state.
            rd_vld     <= bus.imem_en;
            layer_done <= (state == ST_RUN) && is_stop;

            if ((state == ST_IDLE) && start) begin
                pc        <= base_pc;
                instr_cnt <= '0;
            end else begin
                if (bus.imem_en) pc <= pc + PC_W'(1);
                if (present && (instr_cnt != {CNT_W{1'b1}}))
                    instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    assign busy          = (state != ST_IDLE);
    assign bus.imem_addr = pc;

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

    localparam int MAXC = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_pc = 8'h00;
    logic        busy;
    logic        layer_done;
    logic [15:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    logic [9:0] mem [0:255];

    logic       drive_start [MAXC];
    logic [7:0] drive_base  [MAXC];
    logic       drive_rsp   [MAXC];

    logic [9:0]  obs_instr [MAXC];
    logic        obs_en    [MAXC];
    logic [7:0]  obs_addr  [MAXC];
    logic        obs_done  [MAXC];
    logic        obs_busy  [MAXC];
    logic [15:0] obs_cnt   [MAXC];

    layer_sequencer_if #(.PC_W(8)) bus ();

    layer_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_pc    (base_pc),
        .busy       (busy),
        .layer_done (layer_done),
        .instr_cnt  (instr_cnt),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    // synchronous instruction memory
    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_drive();
        for (int c = 0; c < MAXC; c++) begin
            drive_start[c] = 1'b0;
            drive_base[c]  = 8'h00;
            drive_rsp[c]   = 1'b0;
        end
    endtask

    // cycle c = clock period ending at the c-th rising edge of the trace;
    // outputs are sampled and inputs driven at the falling edge inside it
    task automatic run_trace(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            obs_instr[c] = bus.instr_out;
            obs_en[c]    = bus.imem_en;
            obs_addr[c]  = bus.imem_addr;
            obs_done[c]  = layer_done;
            obs_busy[c]  = busy;
            obs_cnt[c]   = instr_cnt;
            start            = drive_start[c];
            base_pc          = drive_base[c];
            bus.load_rsp_vld = drive_rsp[c];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; base_pc = 8'h33; bus.load_rsp_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (layer_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", layer_done); end
        checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", bus.imem_en); end
        checks++; if (bus.instr_out !== 10'h000) begin errors++; $display("FAIL reset_instr got=%h exp=000", bus.instr_out); end
        checks++; if (instr_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", instr_cnt); end
        checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", bus.imem_addr); end
        @(negedge clk); start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_straight_line();
        mem[8'h10] = 10'h200; mem[8'h11] = 10'h083; mem[8'h12] = 10'h380;
        clear_drive(); drive_start[0] = 1'b1; drive_base[0] = 8'h10;
        run_trace(8);
        checks++; if (obs_busy[0] !== 1'b0) begin errors++; $display("FAIL sl_busy0 got=%b exp=0", obs_busy[0]); end
        checks++; if (obs_en[1] !== 1'b1 || obs_addr[1] !== 8'h10) begin errors++; $display("FAIL sl_fetch1 en=%b addr=%h exp en=1 addr=10", obs_en[1], obs_addr[1]); end
        checks++; if (obs_instr[1] !== 10'h000) begin errors++; $display("FAIL sl_instr1 got=%h exp=000", obs_instr[1]); end
        checks++; if (obs_instr[2] !== 10'h200) begin errors++; $display("FAIL sl_instr2 got=%h exp=200", obs_instr[2]); end
        checks++; if (obs_instr[3] !== 10'h083) begin errors++; $display("FAIL sl_instr3 got=%h exp=083", obs_instr[3]); end
        checks++; if (obs_instr[4] !== 10'h380) begin errors++; $display("FAIL sl_instr4 got=%h exp=380", obs_instr[4]); end
        checks++; if (obs_en[4] !== 1'b0) begin errors++; $display("FAIL sl_en4 got=%b exp=0", obs_en[4]); end
        checks++; if (obs_instr[5] !== 10'h000) begin errors++; $display("FAIL sl_instr5 got=%h exp=000", obs_instr[5]); end
        checks++; if (obs_done[4] !== 1'b0 || obs_done[5] !== 1'b1 || obs_done[6] !== 1'b0) begin errors++; $display("FAIL sl_done got=%b%b%b exp=010", obs_done[4], obs_done[5], obs_done[6]); end
        checks++; if (obs_busy[5] !== 1'b1 || obs_busy[6] !== 1'b0) begin errors++; $display("FAIL sl_busy got=%b%b exp=10", obs_busy[5], obs_busy[6]); end
        checks++; if (obs_cnt[7] !== 16'd3) begin errors++; $display("FAIL sl_cnt got=%0d exp=3", obs_cnt[7]); end
    endtask

    task automatic load_program();
        mem[8'h00] = 10'h200; mem[8'h01] = 10'h125; mem[8'h02] = 10'h083; mem[8'h03] = 10'h380;
    endtask

    task automatic test_load_stall();
        load_program();
        clear_drive(); drive_start[0] = 1'b1; drive_base[0] = 8'h00; drive_rsp[7] = 1'b1;
        run_trace(14);
        checks++; if (obs_instr[3] !== 10'h125) begin errors++; $display("FAIL ld_instr3 got=%h exp=125", obs_instr[3]); end
        for (int c = 4; c <= 8; c++) begin
            checks++; if (obs_instr[c] !== 10'h000) begin errors++; $display("FAIL ld_stall_instr c=%0d got=%h exp=000", c, obs_instr[c]); end
        end
        for (int c = 3; c <= 7; c++) begin
            checks++; if (obs_en[c] !== 1'b0) begin errors++; $display("FAIL ld_stall_en c=%0d got=%b exp=0", c, obs_en[c]); end
        end
        checks++; if (obs_en[8] !== 1'b1 || obs_addr[8] !== 8'h02) begin errors++; $display("FAIL ld_resume en=%b addr=%h exp en=1 addr=02", obs_en[8], obs_addr[8]); end
        checks++; if (obs_instr[9] !== 10'h083) begin errors++; $display("FAIL ld_instr9 got=%h exp=083", obs_instr[9]); end
        checks++; if (obs_done[11] !== 1'b1) begin errors++; $display("FAIL ld_done got=%b exp=1", obs_done[11]); end
        checks++; if (obs_cnt[13] !== 16'd4) begin errors++; $display("FAIL ld_cnt got=%0d exp=4", obs_cnt[13]); end
    endtask

    task automatic test_spurious_rsp();
        load_program();
        clear_drive(); drive_start[0] = 1'b1; drive_base[0] = 8'h00;
        drive_rsp[2] = 1'b1; drive_rsp[3] = 1'b1; drive_rsp[6] = 1'b1;
        drive_rsp[10] = 1'b1; drive_rsp[11] = 1'b1;
        run_trace(13);
        for (int c = 4; c <= 7; c++) begin
            checks++; if (obs_instr[c] !== 10'h000) begin errors++; $display("FAIL sp_instr c=%0d got=%h exp=000", c, obs_instr[c]); end
        end
        for (int c = 4; c <= 6; c++) begin
            checks++; if (obs_en[c] !== 1'b0) begin errors++; $display("FAIL sp_en c=%0d got=%b exp=0", c, obs_en[c]); end
        end
        checks++; if (obs_en[7] !== 1'b1 || obs_addr[7] !== 8'h02) begin errors++; $display("FAIL sp_resume en=%b addr=%h exp en=1 addr=02", obs_en[7], obs_addr[7]); end
        checks++; if (obs_instr[8] !== 10'h083 || obs_instr[9] !== 10'h380) begin errors++; $display("FAIL sp_tail got=%h,%h exp=083,380", obs_instr[8], obs_instr[9]); end
        checks++; if (obs_done[10] !== 1'b1) begin errors++; $display("FAIL sp_done got=%b exp=1", obs_done[10]); end
        checks++; if (obs_busy[11] !== 1'b0 || obs_busy[12] !== 1'b0) begin errors++; $display("FAIL sp_idle got=%b%b exp=00", obs_busy[11], obs_busy[12]); end
        checks++; if (obs_cnt[12] !== 16'd4) begin errors++; $display("FAIL sp_cnt got=%0d exp=4", obs_cnt[12]); end
    endtask

    task automatic test_start_ignored();
        int ndone;
        mem[8'h10] = 10'h200; mem[8'h11] = 10'h083; mem[8'h12] = 10'h380;
        mem[8'h40] = 10'h201; mem[8'h41] = 10'h202;
        clear_drive(); drive_start[0] = 1'b1; drive_base[0] = 8'h10;
        drive_start[2] = 1'b1; drive_base[2] = 8'h40;
        drive_start[5] = 1'b1; drive_base[5] = 8'h40;
        run_trace(10);
        checks++; if (obs_addr[1] !== 8'h10 || obs_addr[2] !== 8'h11 || obs_addr[3] !== 8'h12) begin errors++; $display("FAIL si_addr got=%h,%h,%h exp=10,11,12", obs_addr[1], obs_addr[2], obs_addr[3]); end
        checks++; if (obs_instr[4] !== 10'h380) begin errors++; $display("FAIL si_stop got=%h exp=380", obs_instr[4]); end
        ndone = 0;
        for (int c = 0; c < 10; c++) if (obs_done[c] === 1'b1) ndone++;
        checks++; if (ndone != 1) begin errors++; $display("FAIL si_ndone got=%0d exp=1", ndone); end
        for (int c = 6; c < 10; c++) begin
            checks++; if (obs_busy[c] !== 1'b0) begin errors++; $display("FAIL si_idle c=%0d got=%b exp=0", c, obs_busy[c]); end
        end
    endtask

    task automatic test_reset_mid_load();
        load_program();
        clear_drive(); drive_start[0] = 1'b1; drive_base[0] = 8'h00;
        run_trace(6);
        checks++; if (obs_busy[5] !== 1'b1 || obs_instr[5] !== 10'h000) begin errors++; $display("FAIL rm_wait busy=%b instr=%h exp busy=1 instr=000", obs_busy[5], obs_instr[5]); end
        #2; rst_n = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
        checks++; if (bus.imem_en !== 1'b0 || bus.instr_out !== 10'h000) begin errors++; $display("FAIL rm_bus en=%b instr=%h exp en=0 instr=000", bus.imem_en, bus.instr_out); end
        checks++; if (instr_cnt !== 16'd0 || bus.imem_addr !== 8'h00) begin errors++; $display("FAIL rm_regs cnt=%0d addr=%h exp cnt=0 addr=00", instr_cnt, bus.imem_addr); end
        @(negedge clk); bus.load_rsp_vld = 1'b1;
        @(negedge clk);
        checks++; if (layer_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_hold done=%b busy=%b exp done=0 busy=0", layer_done, busy); end
        bus.load_rsp_vld = 1'b0; rst_n = 1'b1;
        mem[8'h10] = 10'h200; mem[8'h11] = 10'h083; mem[8'h12] = 10'h380;
        clear_drive(); drive_start[0] = 1'b1; drive_base[0] = 8'h10;
        run_trace(8);
        checks++; if (obs_instr[2] !== 10'h200 || obs_instr[3] !== 10'h083 || obs_instr[4] !== 10'h380) begin errors++; $display("FAIL rm_fresh got=%h,%h,%h exp=200,083,380", obs_instr[2], obs_instr[3], obs_instr[4]); end
        checks++; if (obs_done[5] !== 1'b1 || obs_done[1] !== 1'b0) begin errors++; $display("FAIL rm_fresh_done got=%b%b exp=01", obs_done[1], obs_done[5]); end
        checks++; if (obs_cnt[7] !== 16'd3) begin errors++; $display("FAIL rm_fresh_cnt got=%0d exp=3", obs_cnt[7]); end
    endtask

    task automatic test_pc_wrap();
        mem[8'hFF] = 10'h200; mem[8'h00] = 10'h380;
        clear_drive(); drive_start[0] = 1'b1; drive_base[0] = 8'hFF;
        run_trace(7);
        checks++; if (obs_en[1] !== 1'b1 || obs_addr[1] !== 8'hFF) begin errors++; $display("FAIL wr_addr1 en=%b addr=%h exp en=1 addr=ff", obs_en[1], obs_addr[1]); end
        checks++; if (obs_en[2] !== 1'b1 || obs_addr[2] !== 8'h00) begin errors++; $display("FAIL wr_addr2 en=%b addr=%h exp en=1 addr=00", obs_en[2], obs_addr[2]); end
        checks++; if (obs_instr[2] !== 10'h200 || obs_instr[3] !== 10'h380) begin errors++; $display("FAIL wr_instr got=%h,%h exp=200,380", obs_instr[2], obs_instr[3]); end
        checks++; if (obs_done[4] !== 1'b1 || obs_busy[5] !== 1'b0) begin errors++; $display("FAIL wr_end done=%b busy=%b exp done=1 busy=0", obs_done[4], obs_busy[5]); end
    endtask

    // Reference model: walks the program from base; each instruction is shown
    // one cycle after it is fetched; a LOAD shown at t resumes two cycles after
    // the first response pulse at or after t+1; STOP at t gives done at t+1.
    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int base, n, t, stop_t, addr, r, ncyc, pcount;
            bit fin;
            logic [2:0] op3;
            logic [9:0] ins;
            bit         ev [MAXC];
            logic [9:0] ei [MAXC];
            bit         ef [MAXC];
            logic [7:0] ea [MAXC];
            base = $urandom_range(0, 255);
            n    = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 7))
                    0: op3 = OP_NOP;   1: op3 = OP_STORE; 2: op3 = OP_LOAD; 3: op3 = OP_LOAD;
                    4: op3 = OP_ACC0;  5: op3 = OP_ACCI;  6: op3 = 3'b011;  default: op3 = 3'b101;
                endcase
                mem[(base + i) % 256] = {op3, 7'($urandom_range(0, 127))};
            end
            mem[(base + n) % 256] = {OP_STOP, 7'($urandom_range(0, 127))};
            clear_drive();
            for (int c = 0; c < MAXC; c++) drive_rsp[c] = ($urandom_range(0, 5) == 0);
            for (int c = 0; c < MAXC; c++) begin ev[c] = 0; ei[c] = '0; ef[c] = 0; ea[c] = '0; end
            t = 2; addr = base; stop_t = 0; fin = 0;
            while (!fin) begin
                ins = mem[addr];
                ev[t] = 1; ei[t] = ins; ef[t-1] = 1; ea[t-1] = 8'(addr);
                if (ins[9:7] == OP_STOP) begin
                    stop_t = t; fin = 1;
                end else begin
                    if (ins[9:7] == OP_LOAD) begin
                        r = -1;
                        for (int k = t + 1; k <= t + 6; k++) if (drive_rsp[k] && r < 0) r = k;
                        if (r < 0) begin r = t + 1 + $urandom_range(0, 5); drive_rsp[r] = 1'b1; end
                        t = r + 2;
                    end else begin
                        t = t + 1;
                    end
                    addr = (addr + 1) % 256;
                end
            end
            drive_start[0] = 1'b1; drive_base[0] = 8'(base);
            for (int c = 1; c <= stop_t + 1; c++)
                if ($urandom_range(0, 7) == 0) begin drive_start[c] = 1'b1; drive_base[c] = 8'($urandom_range(0, 255)); end
            ncyc = stop_t + 3;
            run_trace(ncyc);
            pcount = 0;
            for (int c = 0; c < ncyc; c++) begin
                checks++; if (obs_instr[c] !== (ev[c] ? ei[c] : 10'h000)) begin errors++; $display("FAIL rnd_instr it=%0d c=%0d got=%h exp=%h", it, c, obs_instr[c], ev[c] ? ei[c] : 10'h000); end
                checks++; if (obs_en[c] !== ef[c]) begin errors++; $display("FAIL rnd_en it=%0d c=%0d got=%b exp=%b", it, c, obs_en[c], ef[c]); end
                if (ef[c]) begin
                    checks++; if (obs_addr[c] !== ea[c]) begin errors++; $display("FAIL rnd_addr it=%0d c=%0d got=%h exp=%h", it, c, obs_addr[c], ea[c]); end
                end
                checks++; if (obs_done[c] !== (c == stop_t + 1)) begin errors++; $display("FAIL rnd_done it=%0d c=%0d got=%b exp=%b", it, c, obs_done[c], (c == stop_t + 1)); end
                checks++; if (obs_busy[c] !== (c >= 1 && c <= stop_t + 1)) begin errors++; $display("FAIL rnd_busy it=%0d c=%0d got=%b exp=%b", it, c, obs_busy[c], (c >= 1 && c <= stop_t + 1)); end
                if (c >= 1) begin
                    checks++; if (obs_cnt[c] !== 16'(pcount)) begin errors++; $display("FAIL rnd_cnt it=%0d c=%0d got=%0d exp=%0d", it, c, obs_cnt[c], pcount); end
                end
                if (ev[c]) pcount++;
            end
        end
    endtask

    initial begin
        bus.load_rsp_vld = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 10'h000;
        test_reset();
        test_straight_line();
        test_load_stall();
        test_spurious_rsp();
        test_start_ignored();
        test_reset_mid_load();
        test_pc_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
